// File: rtl/cmd_pkt_pkg.sv
// Shared types and constants for the command-packet receiver.
package cmd_pkt_pkg;

    typedef enum logic [2:0] {ST_HUNT, ST_LEN, ST_DATA, ST_CHK, ST_DONE} cmd_st_t;
    typedef enum logic [2:0] {WB_IDLE, WB_REQ, WB_WAIT, WB_BEAT0, WB_BEAT1} wb_st_t;

    localparam logic [3:0] ERR_OK  = 4'd0;
    localparam logic [3:0] ERR_LEN = 4'd1;
    localparam logic [3:0] ERR_XOR = 4'd2;
    localparam logic [3:0] ERR_TMO = 4'd3;

    localparam logic [7:0] STAT_MARK = 8'hA5;

    // Bytes per command word for the default 32-bit word / 8-bit bus geometry.
    localparam int NB_CMD_BYTE = 32 / 8;

    function automatic int LOG2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/shk_byte_word_asm.sv
// Byte strobe detection, little-endian word assembly, byte counting and idle timeout.
module shk_byte_word_asm
    import cmd_pkt_pkg::*;
#(
    parameter int WD_SHK_DATA   = 8,
    parameter int WD_CMD_DATA   = 32,
    parameter int WD_SLEEP_SPAN = 30,
    parameter int NB_BYTE       = NB_CMD_BYTE
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   rdy,
    input  logic [WD_SHK_DATA-1:0] data,
    input  logic                   clr,
    output logic [WD_CMD_DATA-1:0] word,
    output logic                   byte_vld,
    output logic                   word_vld,
    output logic                   tmo
);

    localparam int CNT_W = (NB_BYTE > 1) ? LOG2(NB_BYTE) : 1;

    logic                     rdy_p0;
    logic                     stb_p0;
    logic [WD_SHK_DATA-1:0]   byte_p0;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_base;
    logic [WD_SLEEP_SPAN-1:0] idle;

    // A start-word match realigns the counter even if a byte lands in the same cycle.
    assign cnt_base = clr ? '0 : cnt;
    assign tmo      = idle[WD_SLEEP_SPAN-1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdy_p0   <= 1'b0;
            stb_p0   <= 1'b0;
            byte_p0  <= '0;
            word     <= '0;
            byte_vld <= 1'b0;
            word_vld <= 1'b0;
            cnt      <= '0;
            idle     <= '0;
        end else begin
            // stage p0: rising-edge detect of the byte ready line
            rdy_p0   <= rdy;
            stb_p0   <= rdy & ~rdy_p0;
            byte_p0  <= data;
            // stage p1: shift in at the top so the first byte ends up in the low lane
            byte_vld <= stb_p0;
            word_vld <= 1'b0;
            if (stb_p0) begin
                word <= {byte_p0, word[WD_CMD_DATA-1:WD_SHK_DATA]};
                idle <= '0;
            end else if (!idle[WD_SLEEP_SPAN-1]) begin
                idle <= idle + 1'b1;
            end
            if (stb_p0) begin
                if (cnt_base == CNT_W'(NB_BYTE - 1)) begin
                    cnt      <= '0;
                    word_vld <= 1'b1;
                end else begin
                    cnt <= cnt_base + 1'b1;
                end
            end else begin
                cnt <= cnt_base;
            end
        end
    end

endmodule

// File: rtl/cmd_pkt_rx_chk.sv
// Checked command-packet receiver: start hunt, length/XOR validation, atomic commit, status write-back.
module cmd_pkt_rx_chk
    import cmd_pkt_pkg::*;
#(
    parameter logic [31:0] MD_CMD_START  = 32'h1331_0001,
    parameter int          NB_CMD_ORDE   = 128,
    parameter int          WD_CMD_DATA   = 32,
    parameter int          WD_SHK_DATA   = 8,
    parameter int          WD_SHK_ADDR   = 8,
    parameter int          WD_BCK_DATA   = 32,
    parameter int          WD_BCK_ADDR   = 32,
    parameter int          WD_SLEEP_SPAN = 30,
    parameter int          WD_ERR_INFO   = 4
) (
    input  logic                               i_sys_clk,
    input  logic                               i_sys_resetn,
    output logic                               m_shk_rd_valid,
    output logic                               m_shk_rd_msync,
    output logic [WD_SHK_DATA-1:0]             m_shk_rd_mdata,
    output logic [WD_SHK_ADDR-1:0]             m_shk_rd_maddr,
    input  logic                               m_shk_rd_ready,
    input  logic [WD_SHK_DATA-1:0]             m_shk_rd_sdata,
    output logic [WD_CMD_DATA*NB_CMD_ORDE-1:0] m_cmd_dst_arry,
    output logic                               m_cmd_dst_updt,
    output logic                               m_shk_wr_valid,
    output logic                               m_shk_wr_msync,
    output logic [WD_BCK_DATA-1:0]             m_shk_wr_mdata,
    output logic [WD_BCK_ADDR-1:0]             m_shk_wr_maddr,
    input  logic                               m_shk_wr_ready,
    input  logic                               m_shk_wr_ssync,
    output logic [WD_ERR_INFO-1:0]             m_err_cmd_info1
);

    localparam int WD_IDX = LOG2(NB_CMD_ORDE + 1);
    localparam int WD_SEL = (NB_CMD_ORDE > 1) ? LOG2(NB_CMD_ORDE) : 1;

    logic [WD_CMD_DATA-1:0] word;
    logic                   byte_vld;
    logic                   word_vld;
    logic                   tmo;
    logic                   hunt_hit;
    logic                   len_ok;

    cmd_st_t                st;
    wb_st_t                 wb;
    logic [WD_CMD_DATA-1:0] len_word;
    logic [WD_IDX-1:0]      len_idx;
    logic [WD_SEL-1:0]      idx;
    logic [WD_CMD_DATA-1:0] xor_acc;
    logic [3:0]             err;
    logic [7:0]             seq;
    logic [31:0]            stat;
    logic                   pend;

    logic [NB_CMD_ORDE-1:0][WD_CMD_DATA-1:0] shadow;
    logic [NB_CMD_ORDE-1:0][WD_CMD_DATA-1:0] arry;

    shk_byte_word_asm #(
        .WD_SHK_DATA  (WD_SHK_DATA),
        .WD_CMD_DATA  (WD_CMD_DATA),
        .WD_SLEEP_SPAN(WD_SLEEP_SPAN),
        .NB_BYTE      (WD_CMD_DATA / WD_SHK_DATA)
    ) u_asm (
        .clk     (i_sys_clk),
        .resetn  (i_sys_resetn),
        .rdy     (m_shk_rd_ready),
        .data    (m_shk_rd_sdata),
        .clr     (hunt_hit),
        .word    (word),
        .byte_vld(byte_vld),
        .word_vld(word_vld),
        .tmo     (tmo)
    );

    assign hunt_hit = (st == ST_HUNT) && byte_vld && (word == WD_CMD_DATA'(MD_CMD_START));
    assign len_ok   = (word != '0) && (word <= WD_CMD_DATA'(NB_CMD_ORDE));

    assign m_shk_rd_valid  = 1'b1;
    assign m_shk_rd_msync  = 1'b0;
    assign m_shk_rd_mdata  = '0;
    assign m_shk_rd_maddr  = '0;
    assign m_shk_wr_maddr  = WD_BCK_ADDR'(MD_CMD_START);
    assign m_cmd_dst_arry  = arry;

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_resetn) begin
            st              <= ST_HUNT;
            len_word        <= '0;
            len_idx         <= '0;
            idx             <= '0;
            xor_acc         <= '0;
            err             <= ERR_OK;
            seq             <= '0;
            stat            <= '0;
            shadow          <= '0;
            arry            <= '0;
            m_cmd_dst_updt  <= 1'b0;
            m_err_cmd_info1 <= '0;
        end else begin
            m_cmd_dst_updt <= 1'b0;
            case (st)
                ST_HUNT: if (hunt_hit) begin
                    xor_acc <= '0;
                    idx     <= '0;
                    st      <= ST_LEN;
                end
                ST_LEN: if (word_vld) begin
                    len_word <= word;
                    len_idx  <= WD_IDX'(word);
                    xor_acc  <= word;
                    if (!len_ok) begin
                        err <= ERR_LEN;
                        st  <= ST_DONE;
                    end else begin
                        st <= ST_DATA;
                    end
                end else if (tmo) begin
                    err <= ERR_TMO;
                    st  <= ST_DONE;
                end
                ST_DATA: if (word_vld) begin
                    shadow[idx] <= word;
                    xor_acc     <= xor_acc ^ word;
                    idx         <= idx + 1'b1;
                    if ((WD_IDX'(idx) + 1'b1) == len_idx) st <= ST_CHK;
                end else if (tmo) begin
                    err <= ERR_TMO;
                    st  <= ST_DONE;
                end
                ST_CHK: if (word_vld) begin
                    err <= (word == xor_acc) ? ERR_OK : ERR_XOR;
                    st  <= ST_DONE;
                end else if (tmo) begin
                    err <= ERR_TMO;
                    st  <= ST_DONE;
                end
                ST_DONE: begin
                    // Only the words this packet carried are replaced; the rest keep prior commands.
                    if (err == ERR_OK) begin
                        for (int j = 0; j < NB_CMD_ORDE; j++)
                            if (WD_IDX'(j) < len_idx) arry[j] <= shadow[j];
                        m_cmd_dst_updt <= 1'b1;
                    end
                    m_err_cmd_info1 <= WD_ERR_INFO'(err);
                    stat            <= {STAT_MARK, seq, len_word[7:0], 4'h0, err};
                    seq             <= seq + 1'b1;
                    st              <= ST_HUNT;
                end
                default: st <= ST_HUNT;
            endcase
        end
    end

    // Single-slot status report: a later packet refreshes the pending status in place.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_resetn) begin
            wb             <= WB_IDLE;
            pend           <= 1'b0;
            m_shk_wr_valid <= 1'b0;
            m_shk_wr_msync <= 1'b0;
            m_shk_wr_mdata <= '0;
        end else begin
            if (st == ST_DONE) pend <= 1'b1;
            case (wb)
                WB_IDLE: if (pend) begin
                    m_shk_wr_valid <= 1'b1;
                    wb             <= WB_REQ;
                end
                WB_REQ: if (m_shk_wr_ready) begin
                    m_shk_wr_valid <= 1'b0;
                    wb             <= WB_WAIT;
                end
                WB_WAIT: if (m_shk_wr_ssync) begin
                    m_shk_wr_msync <= 1'b1;
                    m_shk_wr_mdata <= WD_BCK_DATA'(MD_CMD_START);
                    wb             <= WB_BEAT0;
                end
                WB_BEAT0: begin
                    m_shk_wr_mdata <= WD_BCK_DATA'(stat);
                    wb             <= WB_BEAT1;
                end
                WB_BEAT1: begin
                    m_shk_wr_msync <= 1'b0;
                    m_shk_wr_mdata <= '0;
                    pend           <= (st == ST_DONE);
                    wb             <= WB_IDLE;
                end
                default: wb <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_pkt_rx_chk.sv
// Randomized packet stimulus against a packet-level reference model of the receiver.
module tb_cmd_pkt_rx_chk;

    localparam int          NB    = 128;
    localparam logic [31:0] START = 32'h1331_0001;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              rd_ready = 1'b0;
    logic [7:0]        sdata = '0;
    logic              wr_ready = 1'b1;
    logic              ssync = 1'b1;
    logic              rd_valid, rd_msync, updt, wr_valid, msync;
    logic [7:0]        rd_mdata, rd_maddr;
    logic [32*NB-1:0]  arry;
    logic [31:0]       mdata, maddr;
    logic [3:0]        err_info;

    int n_chk = 0;
    int n_fail = 0;
    int updt_cnt = 0;
    int req_cnt = 0;
    logic valid_q = 1'b0;

    logic [31:0] exp_arr [NB];
    int          exp_updt = 0;
    logic [7:0]  seq = '0;

    always #5 clk = ~clk;

    cmd_pkt_rx_chk #(.WD_SLEEP_SPAN(8)) dut (
        .i_sys_clk      (clk),
        .i_sys_resetn   (resetn),
        .m_shk_rd_valid (rd_valid),
        .m_shk_rd_msync (rd_msync),
        .m_shk_rd_mdata (rd_mdata),
        .m_shk_rd_maddr (rd_maddr),
        .m_shk_rd_ready (rd_ready),
        .m_shk_rd_sdata (sdata),
        .m_cmd_dst_arry (arry),
        .m_cmd_dst_updt (updt),
        .m_shk_wr_valid (wr_valid),
        .m_shk_wr_msync (msync),
        .m_shk_wr_mdata (mdata),
        .m_shk_wr_maddr (maddr),
        .m_shk_wr_ready (wr_ready),
        .m_shk_wr_ssync (ssync),
        .m_err_cmd_info1(err_info)
    );

    always @(negedge clk) begin
        valid_q <= wr_valid;
        if (updt) updt_cnt <= updt_cnt + 1;
        if (wr_valid && !valid_q) req_cnt <= req_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < NB; j++) exp_arr[j] = '0;
        seq = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    // Packet-level rule: length range first, then XOR of LEN and payload against the trailer.
    function automatic logic [3:0] model_err(input logic [31:0] p[$]);
        logic [31:0] x;
        int len;
        if (p[1] == 0 || p[1] > NB) return 4'd1;
        len = int'(p[1]);
        x = '0;
        for (int i = 1; i <= len + 1; i++) x ^= p[i];
        return (x == p[len + 2]) ? 4'd0 : 4'd2;
    endfunction

    task automatic mk_pkt(input int len, input bit bad, output logic [31:0] p[$]);
        logic [31:0] x, w;
        p = {};
        p.push_back(START);
        p.push_back(32'(len));
        if (len >= 1 && len <= NB) begin
            x = 32'(len);
            for (int i = 0; i < len; i++) begin
                w = $urandom;
                p.push_back(w);
                x ^= w;
            end
            p.push_back(bad ? (x ^ ($urandom | 32'd1)) : x);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input bit exp_up);
        logic [3:0] seen;
        @(negedge clk);
        sdata = b;
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        if (last) begin
            seen[0] = updt;
            for (int i = 1; i < 4; i++) begin
                @(negedge clk);
                seen[i] = updt;
            end
            chk("updt_latency", {60'd0, seen}, exp_up ? 64'h8 : 64'h0);
        end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit last, input bit exp_up);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], last && (k == 3), exp_up);
    endtask

    task automatic send_pkt(input logic [31:0] p[$], input int ngarb, output logic [31:0] stat,
                            output logic [3:0] err);
        int len;
        err  = model_err(p);
        stat = {8'hA5, seq, p[1][7:0], 4'h0, err};
        for (int g = 0; g < ngarb; g++) send_byte(8'($urandom_range(8'h20, 8'hFF)), 1'b0, 1'b0);
        for (int i = 0; i < p.size(); i++) send_word(p[i], i == p.size() - 1, err == 4'd0);
        if (err == 4'd0) begin
            len = int'(p[1]);
            for (int j = 0; j < len; j++) exp_arr[j] = p[j + 2];
            exp_updt++;
        end
        seq++;
    endtask

    task automatic wait_beats(input logic [31:0] stat);
        int n;
        n = 0;
        @(negedge clk);
        while (!msync && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wb_beat0_sync", 64'(msync), 64'd1);
        chk("wb_beat0", 64'(mdata), 64'(START));
        @(negedge clk);
        chk("wb_beat1_sync", 64'(msync), 64'd1);
        chk("wb_beat1", 64'(mdata), 64'(stat));
        @(negedge clk);
        chk("wb_idle", {31'd0, wr_valid, msync, mdata}, 64'd0);
    endtask

    task automatic chk_arr();
        for (int j = 0; j < NB; j++)
            chk($sformatf("arr[%0d]", j), 64'(arry[32*j +: 32]), 64'(exp_arr[j]));
    endtask

    task automatic post_chk(input logic [31:0] stat, input logic [3:0] err);
        wait_beats(stat);
        chk("err_info", 64'(err_info), 64'(err));
        chk("updt_count", 64'(updt_cnt), 64'(exp_updt));
        chk_arr();
    endtask

    task automatic run_pkt(input logic [31:0] p[$], input int ngarb);
        logic [31:0] stat;
        logic [3:0]  err;
        send_pkt(p, ngarb, stat, err);
        post_chk(stat, err);
    endtask

    initial begin
        logic [31:0] p[$];
        logic [31:0] stat, stat_b;
        logic [3:0]  err, err_b;
        int          r0, n, kind;

        model_reset();
        do_reset();
        chk("rst_rd_valid", 64'(rd_valid), 64'd1);
        chk("rst_wr_maddr", 64'(maddr), 64'(START));
        chk("rst_rd_tied", {47'd0, rd_msync, rd_mdata, rd_maddr}, 64'd0);
        chk("rst_outs", {26'd0, updt, wr_valid, msync, mdata, err_info}, 64'd0);
        chk_arr();

        // Directed LEN=3 packet; trailer 3 ^ 0x11111111 ^ 0x22222222 ^ 0x33333333 = 3.
        p = {START, 32'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_0003};
        run_pkt(p, 0);
        p = {START, 32'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_0000};
        run_pkt(p, 2);

        p = {START, 32'd0};
        run_pkt(p, 1);
        p = {START, 32'(NB + 1)};
        run_pkt(p, 0);
        mk_pkt(4, 1'b0, p);
        run_pkt(p, 3);
        mk_pkt(NB, 1'b0, p);
        run_pkt(p, 0);

        // Stall mid-payload long enough for the idle timeout, then garbage before a good packet.
        p = {START, 32'd3, 32'hDEAD_BEEF};
        for (int i = 0; i < p.size(); i++) send_word(p[i], 1'b0, 1'b0);
        stat = {8'hA5, seq, 8'd3, 4'h0, 4'd3};
        seq++;
        post_chk(stat, 4'd3);
        mk_pkt(2, 1'b0, p);
        run_pkt(p, 6);

        for (int t = 0; t < 12; t++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                p = {START, ($urandom_range(0, 1) == 0) ? 32'd0 : 32'(NB + 1 + $urandom_range(0, 500))};
            end else begin
                mk_pkt($urandom_range(1, 8), kind == 1, p);
            end
            run_pkt(p, $urandom_range(0, 4));
        end

        // Reset in the middle of a packet leaves nothing committed.
        p = {START, 32'd5, $urandom, $urandom};
        for (int i = 0; i < p.size(); i++) send_word(p[i], 1'b0, 1'b0);
        do_reset();
        chk("midrst_updt", 64'(updt), 64'd0);
        chk_arr();
        mk_pkt(2, 1'b0, p);
        run_pkt(p, 0);

        // Two packets finish while the report is blocked: one request, latest status.
        do_reset();
        wr_ready = 1'b0;
        ssync = 1'b0;
        r0 = req_cnt;
        mk_pkt(2, 1'b0, p);
        send_pkt(p, 0, stat, err);
        mk_pkt(3, 1'b0, p);
        send_pkt(p, 1, stat_b, err_b);
        repeat (4) @(negedge clk);
        chk("wr_valid_hold", 64'(wr_valid), 64'd1);
        wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("wr_valid_drop", 64'(wr_valid), 64'd0);
        chk("wb_seq_field", 64'(stat_b[23:16]), 64'd1);
        ssync = 1'b1;
        post_chk(stat_b, err_b);
        chk("one_request", 64'(req_cnt - r0), 64'd1);

        // Reset while the status beats are on the bus.
        mk_pkt(1, 1'b0, p);
        send_pkt(p, 0, stat, err);
        n = 0;
        while (!msync && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rstwb_seen", 64'(msync), 64'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("rstwb_drop", {62'd0, msync, wr_valid}, 64'd0);
        resetn = 1'b1;
        model_reset();
        @(negedge clk);
        chk_arr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
